// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit CPU: opcodes, ALU codes, bus selects, CCR bits, controller states.
// S_HALT exists only when CU_ILLEGAL_TRAP_EN is defined.
package cpu_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_INCB    = 8'h47;
  localparam logic [7:0] OP_DECA    = 8'h48;
  localparam logic [7:0] OP_DECB    = 8'h49;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BEQ     = 8'h23;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_INC = 3'b100;
  localparam logic [2:0] ALU_DEC = 3'b101;

  localparam logic [1:0] FROM_ALU    = 2'b00;
  localparam logic [1:0] FROM_TO_BUS = 2'b01;
  localparam logic [1:0] FROM_MEM    = 2'b10;

  localparam logic [1:0] TO_PC = 2'b00;
  localparam logic [1:0] TO_A  = 2'b01;
  localparam logic [1:0] TO_B  = 2'b10;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  typedef enum logic [3:0] {
    S_FETCH_0  = 4'd0,
    S_FETCH_1  = 4'd1,
    S_FETCH_2  = 4'd2,
    S_DECODE_3 = 4'd3,
    S_EXEC_4   = 4'd4,
    S_EXEC_5   = 4'd5,
    S_EXEC_6   = 4'd6,
    S_EXEC_7   = 4'd7
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    S_HALT     = 4'd8
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_LD_IMM  = 3'd1,
    CLS_LD_DIR  = 3'd2,
    CLS_ST_DIR  = 3'd3,
    CLS_ALU     = 3'd4,
    CLS_BRANCH  = 3'd5
  } instr_class_t;

  typedef enum logic {
    REG_A = 1'b0,
    REG_B = 1'b1
  } reg_sel_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: classifies IR, picks the target register and ALU code,
// and evaluates the branch condition against the current flags.
module control_decode
  import cpu_pkg::*;
(
  input  logic [7:0]   i_ir,
  input  logic [3:0]   i_ccr,
  output instr_class_t o_instr_class,
  output reg_sel_t     o_reg_sel,
  output logic [2:0]   o_alu_code,
  output logic         o_branch_taken
);

  // V and C are not used by any branch in this instruction set.
  logic w_ccr_unused;
  assign w_ccr_unused = ^{i_ccr[CCR_V], i_ccr[CCR_C]};

  always_comb begin
    o_instr_class  = CLS_ILLEGAL;
    o_reg_sel      = REG_A;
    o_alu_code     = ALU_ADD;
    o_branch_taken = 1'b0;
    case (i_ir)
      OP_LDA_IMM: o_instr_class = CLS_LD_IMM;
      OP_LDB_IMM: begin o_instr_class = CLS_LD_IMM; o_reg_sel = REG_B; end
      OP_LDA_DIR: o_instr_class = CLS_LD_DIR;
      OP_LDB_DIR: begin o_instr_class = CLS_LD_DIR; o_reg_sel = REG_B; end
      OP_STA_DIR: o_instr_class = CLS_ST_DIR;
      OP_STB_DIR: begin o_instr_class = CLS_ST_DIR; o_reg_sel = REG_B; end
      OP_ADD_AB:  begin o_instr_class = CLS_ALU; o_alu_code = ALU_ADD; end
      OP_SUB_AB:  begin o_instr_class = CLS_ALU; o_alu_code = ALU_SUB; end
      OP_AND_AB:  begin o_instr_class = CLS_ALU; o_alu_code = ALU_AND; end
      OP_OR_AB:   begin o_instr_class = CLS_ALU; o_alu_code = ALU_OR;  end
      OP_INCA:    begin o_instr_class = CLS_ALU; o_alu_code = ALU_INC; end
      OP_DECA:    begin o_instr_class = CLS_ALU; o_alu_code = ALU_DEC; end
      OP_INCB:    begin o_instr_class = CLS_ALU; o_alu_code = ALU_INC; o_reg_sel = REG_B; end
      OP_DECB:    begin o_instr_class = CLS_ALU; o_alu_code = ALU_DEC; o_reg_sel = REG_B; end
      OP_BRA:     begin o_instr_class = CLS_BRANCH; o_branch_taken = 1'b1; end
      OP_BMI:     begin o_instr_class = CLS_BRANCH; o_branch_taken = i_ccr[CCR_N]; end
      OP_BEQ:     begin o_instr_class = CLS_BRANCH; o_branch_taken = i_ccr[CCR_Z]; end
      default:    ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// FSM controller for the 8-bit CPU: fetch, decode and execute with Moore strobes to the data path.
// Define CU_ILLEGAL_TRAP_EN to trap unknown opcodes into S_HALT instead of treating them as NOPs.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR,
  output logic       IR_LOAD,
  output logic       MAR_LOAD,
  output logic       PC_LOAD,
  output logic       PC_INC,
  output logic       A_LOAD,
  output logic       B_LOAD,
  output logic       CCR_LOAD,
  output logic [2:0] ALU_SEL,
  output logic [1:0] FROM_MEMORY_BUS_SEL,
  output logic [1:0] TO_MEMORY_BUS_SEL,
  output logic       write,
  output logic       halted
);

  state_t       r_state;
  state_t       w_state_next;
  logic         r_taken;
  instr_class_t w_class;
  reg_sel_t     w_reg_sel;
  logic [2:0]   w_alu_code;
  logic         w_branch_taken;

  control_decode u_decode (
    .i_ir           (IR),
    .i_ccr          (CCR),
    .o_instr_class  (w_class),
    .o_reg_sel      (w_reg_sel),
    .o_alu_code     (w_alu_code),
    .o_branch_taken (w_branch_taken)
  );

  // The branch decision is frozen in D3 so later flag changes cannot alter E5/E6.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH_0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE_3) begin
        r_taken <= w_branch_taken;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH_0:  w_state_next = S_FETCH_1;
      S_FETCH_1:  w_state_next = S_FETCH_2;
      S_FETCH_2:  w_state_next = S_DECODE_3;
      S_DECODE_3: begin
        if (w_class == CLS_ILLEGAL) begin
`ifdef CU_ILLEGAL_TRAP_EN
          w_state_next = S_HALT;
`else
          w_state_next = S_FETCH_0;
`endif
        end else begin
          w_state_next = S_EXEC_4;
        end
      end
      S_EXEC_4:   w_state_next = (w_class == CLS_ALU) ? S_FETCH_0 : S_EXEC_5;
      S_EXEC_5:   w_state_next = (w_class == CLS_BRANCH && !r_taken) ? S_FETCH_0 : S_EXEC_6;
      S_EXEC_6:   w_state_next = (w_class == CLS_LD_IMM || w_class == CLS_BRANCH) ?
                                 S_FETCH_0 : S_EXEC_7;
      S_EXEC_7:   w_state_next = S_FETCH_0;
`ifdef CU_ILLEGAL_TRAP_EN
      S_HALT:     w_state_next = S_HALT;
`endif
      default:    w_state_next = S_FETCH_0;
    endcase
  end

  always_comb begin
    IR_LOAD             = 1'b0;
    MAR_LOAD            = 1'b0;
    PC_LOAD             = 1'b0;
    PC_INC              = 1'b0;
    A_LOAD              = 1'b0;
    B_LOAD              = 1'b0;
    CCR_LOAD            = 1'b0;
    ALU_SEL             = ALU_ADD;
    FROM_MEMORY_BUS_SEL = FROM_ALU;
    TO_MEMORY_BUS_SEL   = TO_PC;
    write               = 1'b0;
    halted              = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH_0: begin
          TO_MEMORY_BUS_SEL   = TO_PC;
          FROM_MEMORY_BUS_SEL = FROM_TO_BUS;
          MAR_LOAD            = 1'b1;
        end
        S_FETCH_1: PC_INC = 1'b1;
        S_FETCH_2: begin
          FROM_MEMORY_BUS_SEL = FROM_MEM;
          IR_LOAD             = 1'b1;
        end
        S_EXEC_4: begin
          if (w_class == CLS_ALU) begin
            TO_MEMORY_BUS_SEL   = (w_reg_sel == REG_A) ? TO_A : TO_B;
            FROM_MEMORY_BUS_SEL = FROM_ALU;
            ALU_SEL             = w_alu_code;
            A_LOAD              = (w_reg_sel == REG_A);
            B_LOAD              = (w_reg_sel == REG_B);
            CCR_LOAD            = 1'b1;
          end else begin
            TO_MEMORY_BUS_SEL   = TO_PC;
            FROM_MEMORY_BUS_SEL = FROM_TO_BUS;
            MAR_LOAD            = 1'b1;
          end
        end
        S_EXEC_5: PC_INC = !(w_class == CLS_BRANCH && r_taken);
        S_EXEC_6: begin
          case (w_class)
            CLS_LD_IMM: begin
              FROM_MEMORY_BUS_SEL = FROM_MEM;
              A_LOAD              = (w_reg_sel == REG_A);
              B_LOAD              = (w_reg_sel == REG_B);
            end
            CLS_LD_DIR, CLS_ST_DIR: begin
              FROM_MEMORY_BUS_SEL = FROM_MEM;
              MAR_LOAD            = 1'b1;
            end
            CLS_BRANCH: begin
              FROM_MEMORY_BUS_SEL = FROM_MEM;
              PC_LOAD             = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC_7: begin
          if (w_class == CLS_LD_DIR) begin
            FROM_MEMORY_BUS_SEL = FROM_MEM;
            A_LOAD              = (w_reg_sel == REG_A);
            B_LOAD              = (w_reg_sel == REG_B);
          end else if (w_class == CLS_ST_DIR) begin
            TO_MEMORY_BUS_SEL   = (w_reg_sel == REG_A) ? TO_A : TO_B;
            write               = 1'b1;
          end
        end
`ifdef CU_ILLEGAL_TRAP_EN
        S_HALT: halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle strobe vectors against an instruction-level
// cycle listing; follows CU_ILLEGAL_TRAP_EN for unknown-opcode behaviour.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] IR = 8'h00;
  logic [3:0] CCR = 4'h0;
  logic       IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD;
  logic [2:0] ALU_SEL;
  logic [1:0] FROM_MEMORY_BUS_SEL, TO_MEMORY_BUS_SEL;
  logic       write, halted;

  control_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .IR                  (IR),
    .CCR                 (CCR),
    .IR_LOAD             (IR_LOAD),
    .MAR_LOAD            (MAR_LOAD),
    .PC_LOAD             (PC_LOAD),
    .PC_INC              (PC_INC),
    .A_LOAD              (A_LOAD),
    .B_LOAD              (B_LOAD),
    .CCR_LOAD            (CCR_LOAD),
    .ALU_SEL             (ALU_SEL),
    .FROM_MEMORY_BUS_SEL (FROM_MEMORY_BUS_SEL),
    .TO_MEMORY_BUS_SEL   (TO_MEMORY_BUS_SEL),
    .write               (write),
    .halted              (halted)
  );

  always #5 clk = ~clk;

  // {IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD, ALU_SEL, FROM, TO, write, halted}
  logic [15:0] obs;
  assign obs = {IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD, ALU_SEL,
                FROM_MEMORY_BUS_SEL, TO_MEMORY_BUS_SEL, write, halted};

  localparam logic [15:0] V_IR   = 16'h8000;
  localparam logic [15:0] V_MAR  = 16'h4000;
  localparam logic [15:0] V_PCL  = 16'h2000;
  localparam logic [15:0] V_PCI  = 16'h1000;
  localparam logic [15:0] V_A    = 16'h0800;
  localparam logic [15:0] V_B    = 16'h0400;
  localparam logic [15:0] V_CCR  = 16'h0200;
  localparam logic [15:0] V_WR   = 16'h0002;
  localparam logic [15:0] V_HALT = 16'h0001;

  logic [15:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] known_ops [17] = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43,
                                 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h20, 8'h21, 8'h23};

  function automatic logic [15:0] f_alu(input logic [2:0] c);
    return {7'b0, c, 6'b0};
  endfunction
  function automatic logic [15:0] f_from(input logic [1:0] s);
    return {10'b0, s, 4'b0};
  endfunction
  function automatic logic [15:0] f_to(input logic [1:0] s);
    return {12'b0, s, 2'b0};
  endfunction

  function automatic bit is_known(input logic [7:0] op);
    foreach (known_ops[i]) if (known_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected strobe vector per cycle for one instruction, starting at its first fetch cycle.
  task automatic model_instr(input logic [7:0] op, input logic [3:0] ccr);
    logic        taken;
    logic [7:0]  d;
    logic [15:0] fetch_opnd;
    logic [15:0] pc_inc_opnd;
    exp_q.delete();
    fetch_opnd  = V_MAR | f_from(2'b01) | f_to(2'b00);
    pc_inc_opnd = V_PCI;
    exp_q.push_back(fetch_opnd);
    exp_q.push_back(V_PCI);
    exp_q.push_back(V_IR | f_from(2'b10));
    exp_q.push_back(16'h0000);
    d = op - 8'h42;
    case (op)
      8'h86, 8'h88: begin
        exp_q.push_back(fetch_opnd);
        exp_q.push_back(pc_inc_opnd);
        exp_q.push_back(f_from(2'b10) | ((op == 8'h86) ? V_A : V_B));
      end
      8'h87, 8'h89: begin
        exp_q.push_back(fetch_opnd);
        exp_q.push_back(pc_inc_opnd);
        exp_q.push_back(f_from(2'b10) | V_MAR);
        exp_q.push_back(f_from(2'b10) | ((op == 8'h87) ? V_A : V_B));
      end
      8'h96, 8'h97: begin
        exp_q.push_back(fetch_opnd);
        exp_q.push_back(pc_inc_opnd);
        exp_q.push_back(f_from(2'b10) | V_MAR);
        exp_q.push_back(f_to((op == 8'h96) ? 2'b01 : 2'b10) | V_WR);
      end
      8'h42, 8'h43, 8'h44, 8'h45:
        exp_q.push_back(V_A | V_CCR | f_to(2'b01) | f_from(2'b00) | f_alu(d[2:0]));
      8'h46: exp_q.push_back(V_A | V_CCR | f_to(2'b01) | f_alu(3'b100));
      8'h48: exp_q.push_back(V_A | V_CCR | f_to(2'b01) | f_alu(3'b101));
      8'h47: exp_q.push_back(V_B | V_CCR | f_to(2'b10) | f_alu(3'b100));
      8'h49: exp_q.push_back(V_B | V_CCR | f_to(2'b10) | f_alu(3'b101));
      8'h20, 8'h21, 8'h23: begin
        taken = (op == 8'h20) || (op == 8'h21 && ccr[3]) || (op == 8'h23 && ccr[2]);
        exp_q.push_back(fetch_opnd);
        exp_q.push_back(taken ? 16'h0000 : pc_inc_opnd);
        if (taken) exp_q.push_back(f_from(2'b10) | V_PCL);
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    CCR = 4'($urandom);
    repeat (2) begin
      @(negedge clk);
      IR = 8'h97;
      #1;
      vectors++;
      if (obs !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_outputs got=%h exp=%h", obs, 16'h0000);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    $display("reset held 2 cycles, released");
  endtask

  task automatic test_directed();
    logic [7:0] ops  [12] = '{8'h86, 8'h42, 8'h23, 8'h23, 8'h97, 8'h21, 8'h21, 8'h20,
                              8'h89, 8'h96, 8'h49, 8'h88};
    logic [3:0] ccrs [12] = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8, 4'h7, 4'h0,
                              4'hF, 4'h3, 4'h0, 4'h5};
    for (int t = 0; t < 12; t++) begin
      model_instr(ops[t], ccrs[t]);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        if (k == 0) begin IR = ops[t]; CCR = ccrs[t]; end
        #1;
        vectors++;
        if (obs !== exp_q[k]) begin
          miscompares++;
          $display("FAIL directed op=%h ccr=%b cyc=%0d got=%h exp=%h",
                   ops[t], ccrs[t], k, obs, exp_q[k]);
        end
      end
      $display("directed op=%h ccr=%b cycles=%0d", ops[t], ccrs[t], exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    model_instr(8'h87, 4'h0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin IR = 8'h87; CCR = 4'h0; end
      if (k == 5) reset = 1'b1;
      #1;
      vectors++;
      if (obs !== ((k == 5) ? 16'h0000 : exp_q[k])) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k, obs,
                 (k == 5) ? 16'h0000 : exp_q[k]);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_instr(8'h88, 4'h0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) IR = 8'h88;
      #1;
      vectors++;
      if (obs !== exp_q[k]) begin
        miscompares++;
        $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
    end
    $display("reset in E5 of LDA_DIR, restart with LDB_IMM cycles=%0d", exp_q.size());
  endtask

  task automatic test_illegal();
    model_instr(8'hFF, 4'h0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin IR = 8'hFF; CCR = 4'h0; end
      #1;
      vectors++;
      if (obs !== exp_q[k]) begin
        miscompares++;
        $display("FAIL illegal_fetch cyc=%0d got=%h exp=%h", k, obs, exp_q[k]);
      end
    end
`ifdef CU_ILLEGAL_TRAP_EN
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      CCR = 4'($urandom);
      #1;
      vectors++;
      if (obs !== V_HALT) begin
        miscompares++;
        $display("FAIL halt_hold cyc=%0d got=%h exp=%h", k, obs, V_HALT);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (obs !== 16'h0000) begin
      miscompares++;
      $display("FAIL halt_reset got=%h exp=%h", obs, 16'h0000);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    $display("illegal op=ff trapped 20 cycles, cleared by reset");
`else
    $display("illegal op=ff executed as nop cycles=%0d", exp_q.size());
`endif
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic [3:0] ccr;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = known_ops[$urandom_range(0, 16)];
`ifdef CU_ILLEGAL_TRAP_EN
      if (!is_known(op)) op = known_ops[$urandom_range(0, 16)];
`endif
      ccr = 4'($urandom);
      model_instr(op, ccr);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        if (k == 0) begin IR = op; CCR = ccr; end
        #1;
        vectors++;
        if (obs !== exp_q[k]) begin
          miscompares++;
          $display("FAIL random op=%h ccr=%b cyc=%0d got=%h exp=%h", op, ccr, k, obs, exp_q[k]);
        end
      end
      $display("random op=%h ccr=%b known=%0d cycles=%0d", op, ccr, is_known(op), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
